// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

    // Fetch FSM: issue a request, wait for the word, or park it in the skid.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
    localparam logic [1:0]  WORD_ALIGN       = 2'b00;

endpackage

// File: rtl/instr_fetch_out_buf.sv
// Output register toward decode plus one skid entry, with flush.
module fetch_out_buf
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              load,
    input  logic              push,
    input  logic [31:0]       data_instr,
    input  logic [ADDR_W-1:0] data_pc,
    input  logic              id_ready,
    output logic              slot_free,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc
);

    logic              skid_valid;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    assign slot_free = ~id_valid | id_ready;

    // Output register: flush wins, then a fresh word, then the skid refill, then drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (load) begin
            id_valid <= 1'b1;
            id_instr <= data_instr;
            id_pc    <= data_pc;
        end else if (skid_valid && id_ready) begin
            id_valid <= 1'b1;
            id_instr <= skid_instr;
            id_pc    <= skid_pc;
        end else if (id_valid && id_ready) begin
            id_valid <= 1'b0;
        end
    end

    // Skid entry: captures a word that arrives while the output is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_instr <= data_instr;
            skid_pc    <= data_pc;
        end else if (skid_valid && id_ready) begin
            skid_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, keeps one memory request in flight, feeds decode.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, WORD_ALIGN};

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] req_pc, req_pc_nxt;
    logic              discard, discard_nxt;
    logic              buf_load, buf_push, slot_free;

    assign imem_req  = (state == REQ) & ~redirect & reset_n;
    assign imem_addr = pc;

    // State, PC and in-flight bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= REQ;
            pc      <= RESET_PC;
            req_pc  <= '0;
            discard <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            req_pc  <= req_pc_nxt;
            discard <= discard_nxt;
        end
    end

    // Next-state logic; a redirect overrides all normal progress.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        req_pc_nxt  = req_pc;
        discard_nxt = discard;
        buf_load    = 1'b0;
        buf_push    = 1'b0;
        if (redirect) begin
            pc_nxt = redirect_pc & ALIGN_MASK;
            unique case (state)
                WAIT: begin
                    // A word landing with the redirect is dropped now; otherwise drop it later.
                    if (imem_rvalid) begin
                        state_nxt   = REQ;
                        discard_nxt = 1'b0;
                    end else begin
                        discard_nxt = 1'b1;
                    end
                end
                default: state_nxt = REQ;
            endcase
        end else begin
            unique case (state)
                REQ: begin
                    req_pc_nxt = pc;
                    pc_nxt     = pc + ADDR_W'(INSTR_BYTES);
                    state_nxt  = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (discard) begin
                            discard_nxt = 1'b0;
                            state_nxt   = REQ;
                        end else if (slot_free) begin
                            buf_load  = 1'b1;
                            state_nxt = REQ;
                        end else begin
                            buf_push  = 1'b1;
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (id_ready) begin
                        state_nxt = REQ;
                    end
                end
                default: state_nxt = REQ;
            endcase
        end
    end

    fetch_out_buf #(
        .ADDR_W (ADDR_W)
    ) u_out_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect),
        .load       (buf_load),
        .push       (buf_push),
        .data_instr (imem_rdata),
        .data_pc    (req_pc),
        .id_ready   (id_ready),
        .slot_free  (slot_free),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic
// against a transaction-level model (expected fetch address and delivery queue).
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model state.
    logic [63:0] mpc;
    logic [63:0] q[$];
    // Memory model state.
    logic        pend;
    int unsigned cnt;
    int unsigned mem_lat;
    logic [63:0] paddr;
    // Last sampled DUT/bench values.
    logic        s_req, s_valid, s_ready, s_redirect;
    logic [63:0] s_addr, s_pc;
    logic [31:0] s_instr;
    logic        p_hold;
    logic [63:0] p_pc;
    logic [31:0] p_instr;
    int unsigned xfers;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W   (64),
        .RESET_PC (64'h0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

    function automatic logic [31:0] memword(input logic [63:0] a);
        logic [31:0] w;
        if (a == 64'h0)      w = 32'hF840_0000;
        else if (a == 64'h4) w = 32'h8B02_0020;
        else                 w = (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, update model, then drive memory response.
    task automatic cycle();
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_valid = id_valid;
        s_pc = id_pc; s_instr = id_instr; s_ready = id_ready; s_redirect = redirect;
        if (p_hold) begin
            chk("stall_valid", {63'd0, s_valid}, 64'd1);
            chk("stall_pc", s_pc, p_pc);
            chk("stall_instr", {32'd0, s_instr}, {32'd0, p_instr});
        end
        if (s_valid && s_ready) begin
            xfers++;
            chk("xfer_expected", {63'd0, q.size() != 0}, 64'd1);
            if (q.size() != 0) begin
                logic [63:0] e;
                e = q.pop_front();
                chk("xfer_pc", s_pc, e);
                chk("xfer_instr", {32'd0, s_instr}, {32'd0, memword(e)});
            end
        end
        if (s_redirect) begin
            q.delete();
            mpc = redirect_pc & ~64'd3;
        end
        if (s_req) begin
            chk("req_addr", s_addr, mpc);
            chk("one_outstanding", {63'd0, pend}, 64'd0);
            q.push_back(mpc);
            mpc = mpc + 64'd4;
            pend = 1'b1; cnt = mem_lat; paddr = s_addr;
        end
        p_hold = s_valid & ~s_ready & ~s_redirect;
        p_pc = s_pc; p_instr = s_instr;
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memword(paddr);
                pend        = 1'b0;
            end
        end
    endtask

    // Asynchronous reset pulse, called just after a rising edge.
    task automatic do_reset();
        reset_n = 1'b0;
        redirect = 1'b0; imem_rvalid = 1'b0;
        #2;
        chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
        chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
        chk("rst_id_instr", {32'd0, id_instr}, 64'd0);
        chk("rst_id_pc", id_pc, 64'd0);
        q.delete(); pend = 1'b0; mpc = 64'h0; p_hold = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = '0; mem_lat = 1; pend = 1'b0;
        mpc = '0; p_hold = 1'b0; xfers = 0;
        @(posedge clk); #1;

        // 1: back-to-back fetch with 1-cycle memory
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t1_req", {63'd0, s_req}, {63'd0, (i % 2) == 0});
            if ((i % 2) == 0) chk("t1_addr", s_addr, 64'(4 * (i / 2)));
            chk("t1_valid", {63'd0, s_valid}, {63'd0, (i >= 2) && ((i % 2) == 0)});
            if (i == 2) chk("t1_pc0", s_pc, 64'h0);
            if (i == 4) chk("t1_pc4", s_pc, 64'h4);
        end

        // 2: decode stall parks the second word in the skid
        do_reset();
        id_ready = 1'b1; cycle(); cycle();
        id_ready = 1'b0; cycle();
        chk("t2_valid", {63'd0, s_valid}, 64'd1);
        chk("t2_addr4", s_addr, 64'h4);
        cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t2_hold_noreq", {63'd0, s_req}, 64'd0);
            chk("t2_hold_pc", s_pc, 64'h0);
            chk("t2_hold_instr", {32'd0, s_instr}, 64'hF840_0000);
        end
        id_ready = 1'b1; cycle();
        chk("t2_first_pc", s_pc, 64'h0);
        cycle();
        chk("t2_skid_valid", {63'd0, s_valid}, 64'd1);
        chk("t2_skid_pc", s_pc, 64'h4);
        chk("t2_skid_instr", {32'd0, s_instr}, 64'h8B02_0020);
        chk("t2_next_req", {63'd0, s_req}, 64'd1);
        chk("t2_next_addr", s_addr, 64'h8);

        // 3: redirect while waiting on a 3-cycle memory
        do_reset();
        mem_lat = 3; id_ready = 1'b1;
        cycle();
        redirect = 1'b1; redirect_pc = 64'h100; cycle();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("t3_noreq", {63'd0, s_req}, 64'd0);
            chk("t3_novalid", {63'd0, s_valid}, 64'd0);
        end
        cycle();
        chk("t3_req", {63'd0, s_req}, 64'd1);
        chk("t3_addr", s_addr, 64'h100);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3_wait_novalid", {63'd0, s_valid}, 64'd0);
        end
        cycle();
        chk("t3_valid", {63'd0, s_valid}, 64'd1);
        chk("t3_pc", s_pc, 64'h100);

        // 4: redirect coinciding with the response
        do_reset();
        mem_lat = 1;
        cycle();
        redirect = 1'b1; redirect_pc = 64'h40; cycle();
        redirect = 1'b0; cycle();
        chk("t4_novalid", {63'd0, s_valid}, 64'd0);
        chk("t4_req", {63'd0, s_req}, 64'd1);
        chk("t4_addr", s_addr, 64'h40);

        // 5: redirect alignment and PC wrap
        do_reset();
        redirect = 1'b1; redirect_pc = 64'h203; cycle();
        chk("t5_noreq", {63'd0, s_req}, 64'd0);
        redirect = 1'b0; cycle();
        chk("t5_align", s_addr, 64'h200);
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; cycle();
        redirect = 1'b0; cycle();
        chk("t5_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(); cycle();
        chk("t5_wrap", s_addr, 64'h0);
        chk("t5_top_pc", s_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // 6: reset while holding a full skid
        do_reset();
        id_ready = 1'b1; cycle(); cycle();
        id_ready = 1'b0; cycle(); cycle(); cycle();
        chk("t6_hold_valid", {63'd0, s_valid}, 64'd1);
        do_reset();
        id_ready = 1'b1; cycle();
        chk("t6_req", {63'd0, s_req}, 64'd1);
        chk("t6_addr", s_addr, 64'h0);
        chk("t6_novalid", {63'd0, s_valid}, 64'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            id_ready    = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 99) < 4);
            redirect_pc = {$urandom, $urandom};
            mem_lat     = $urandom_range(1, 3);
            cycle();
        end
        redirect = 1'b0; id_ready = 1'b1; mem_lat = 1; xfers = 0;
        for (int i = 0; i < 12; i++) cycle();
        chk("drain_backlog", {63'd0, q.size() <= 2}, 64'd1);
        chk("drain_progress", {63'd0, xfers >= 4}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage, directly upstream of decode and the sign-extension stage; supplies the 32-bit instruction word that decode slices into the DAddr9, CondAddr19, BrAddr26 and Imm12 fields.
- Owns the PC. Issues one word request at a time to instruction memory and buffers the returned word into a valid/ready output toward decode.
- Accepts a branch redirect. Downstream computes the target from the sign-extended CondAddr19/BrAddr26 offset (shifted left 2) plus the branch PC.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset; bits [1:0] must be 0.
- ADDR_W, 64, PC/address width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  request strobe, one cycle per request.
- imem_addr  out  ADDR_W  request address; valid while imem_req=1.
- imem_rvalid  in  1  response strobe, at least 1 cycle after imem_req; never in the same cycle.
- imem_rdata  in  32  response word; valid while imem_rvalid=1.
- redirect  in  1  branch taken / flush, single-cycle pulse.
- redirect_pc  in  ADDR_W  new fetch address.
- id_ready  in  1  decode accepts the word this cycle.
- id_valid  out  1  id_instr/id_pc valid.
- id_instr  out  32  fetched instruction.
- id_pc  out  ADDR_W  address of id_instr.

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC, state=REQ.
  - id_valid=0, id_instr=0, id_pc=0.
  - skid empty, discard=0.
  - imem_req=0 while reset is asserted.
- Combinational outputs:
  - imem_req = (state==REQ) & ~redirect.
  - imem_addr = pc.
- Outstanding requests: at most one. Together with a single skid entry this guarantees no response is ever dropped for lack of space.
- FSM states: REQ, WAIT, HOLD.
  - REQ:
    - If imem_req fires: req_pc<=pc, pc<=pc+4 (mod 2^64), go WAIT.
  - WAIT:
    - On imem_rvalid with discard=1: drop the word, clear discard, go REQ.
    - On imem_rvalid with discard=0 and the output slot free (~id_valid | id_ready): load id_instr<=imem_rdata, id_pc<=req_pc, id_valid<=1; go REQ.
    - On imem_rvalid with discard=0 and the output slot occupied: store {imem_rdata, req_pc} in skid, go HOLD.
  - HOLD:
    - On id_ready: move skid to output (id_valid stays 1), go REQ.
- Output handshake:
  - Transfer occurs when id_valid & id_ready.
  - id_valid falls after a transfer unless new data loads in the same cycle.
  - id_instr and id_pc hold stable while id_valid & ~id_ready.
- Latency and throughput:
  - imem_rvalid in cycle N gives id_valid=1 in cycle N+1.
  - With a 1-cycle memory and id_ready tied 1, one instruction every 2 cycles.
- Redirect (priority over everything else):
  - Always: pc<=redirect_pc with bits [1:0] forced to 0; id_valid<=0; skid emptied.
  - In REQ: no request is issued that cycle; stay REQ. The request to the new pc goes out the next cycle.
  - In WAIT without imem_rvalid that cycle: discard<=1, stay WAIT.
  - In WAIT with imem_rvalid the same cycle: drop the word, go REQ.
  - In HOLD: go REQ.
  - Redirect coinciding with id_ready: the held word counts as consumed, and decode ignores it because the branch flushes it.
- Reset mid-operation:
  - All state clears immediately.
  - A response arriving after reset deasserts is ignored while state is REQ (rvalid is only examined in WAIT).

Decomposition:
- Shared package: fetch_state_t enum {REQ, WAIT, HOLD}; INSTR_BYTES=4; RESET_PC default; word-align helper constant (2'b00).
- One sub-module, fetch_out_buf: output register plus skid entry with the valid/ready logic and flush input.
- The FSM and PC stay in instr_fetch.

Test Plan:
1. Reset release, 1-cycle memory returning 32'hF8400000, 32'h8B020020, id_ready=1 -> imem_addr 0x0, 0x4, 0x8; id_pc 0x0 then 0x4; a new id_valid every 2 cycles.
2. id_ready=0 for 5 cycles after the first word -> second word parks in skid, state HOLD, no imem_req, id outputs stable. id_ready=1 -> words 0x0 and 0x4 delivered on consecutive cycles, then fetch of 0x8.
3. Redirect to 0x100 while WAIT with a 3-cycle memory -> late response dropped, next imem_addr=0x100, first id_pc=0x100, no id_valid for the stale word.
4. Redirect in the same cycle as imem_rvalid -> word dropped, id_valid=0 next cycle, request to the redirect address the following cycle.
5. redirect_pc=0x203 -> fetch address 0x200. pc=64'hFFFF_FFFF_FFFF_FFFC -> next fetch 0x0.
6. reset_n pulsed low while HOLD with a full skid -> id_valid=0 asynchronously; after release first imem_addr=RESET_PC, no stale id output.
